// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, load/store size encodings
// and the byte/half extension helpers used by the memory stage.
package mips_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b11;

   function automatic logic [DATA_W-1:0] extend_byte(input logic [7:0] b, input logic is_unsigned);
      return is_unsigned ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
   endfunction

   function automatic logic [DATA_W-1:0] extend_half(input logic [15:0] h, input logic is_unsigned);
      return is_unsigned ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
   endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised single-port data RAM: synchronous write, registered read.
// With MEM_DEBUG_PORT_EN defined it also exposes a combinational debug read port.
module data_memory #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [WIDTH-1:0]  i_wdata,
   output logic [WIDTH-1:0]  o_rdata
`ifdef MEM_DEBUG_PORT_EN
   ,
   input  logic [ADDR_W-1:0] i_debug_addr,
   output logic [WIDTH-1:0]  o_debug_data
`endif
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Contents are deliberately not reset so a pipeline reset leaves stored data intact
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

`ifdef MEM_DEBUG_PORT_EN
   assign o_debug_data = r_mem[i_debug_addr];
`endif

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: sized load/store on the local data memory plus the MEM/WB register.
// Defining MEM_DEBUG_PORT_EN adds the debug-unit memory read port.
module mem_stage #(
   parameter int DATA_W     = 32,
   parameter int MEM_DEPTH  = 256,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_halt,
   input  logic [REG_ADDR_W-1:0] i_write_reg,
   input  logic [DATA_W-1:0]     i_data_to_write_in_MEM,
   input  logic [DATA_W-1:0]     i_ALU_result,
   input  logic                  i_WB_write,
   input  logic                  i_WB_mem_to_reg,
   input  logic                  i_MEM_read,
   input  logic                  i_MEM_write,
   input  logic                  i_MEM_unsigned,
   input  logic [1:0]            i_MEM_byte_half_word,
   output logic                  o_WB_write,
   output logic                  o_WB_mem_to_reg,
   output logic [DATA_W-1:0]     o_ALU_result,
   output logic [DATA_W-1:0]     o_read_data,
   output logic [REG_ADDR_W-1:0] o_write_reg
`ifdef MEM_DEBUG_PORT_EN
   ,
   input  logic [$clog2(MEM_DEPTH)-1:0] i_debug_addr,
   output logic [DATA_W-1:0]            o_debug_data
`endif
);

   import mips_pkg::*;

   localparam int AW = $clog2(MEM_DEPTH);

   function automatic logic [DATA_W-1:0] size_data(input logic [DATA_W-1:0] d,
                                                   input logic [1:0]        sz,
                                                   input logic              is_unsigned);
      case (sz)
         SZ_BYTE: return extend_byte(d[7:0], is_unsigned);
         SZ_HALF: return extend_half(d[15:0], is_unsigned);
         default: return d;
      endcase
   endfunction

   logic [AW-1:0]     w_word_idx;
   logic [DATA_W-1:0] w_store_data;
   logic [DATA_W-1:0] w_mem_q;
   logic              w_we;
   logic              w_re;

   logic                  r_wb_write;
   logic                  r_wb_mem_to_reg;
   logic [DATA_W-1:0]     r_alu_result;
   logic [REG_ADDR_W-1:0] r_write_reg;
   logic                  r_load;
   logic [1:0]            r_load_size;
   logic                  r_load_unsigned;

   assign w_word_idx   = i_ALU_result[AW+1:2];
   assign w_store_data = size_data(i_data_to_write_in_MEM, i_MEM_byte_half_word, i_MEM_unsigned);

   // Reset in the write enable drops a store that coincides with an asserted reset
   assign w_we = i_MEM_write & ~i_halt & i_reset;
   assign w_re = i_MEM_read & ~i_halt;

   data_memory #(
      .WIDTH  (DATA_W),
      .DEPTH  (MEM_DEPTH),
      .ADDR_W (AW)
   ) u_data_memory (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_we         (w_we),
      .i_re         (w_re),
      .i_addr       (w_word_idx),
      .i_wdata      (w_store_data),
      .o_rdata      (w_mem_q)
`ifdef MEM_DEBUG_PORT_EN
      ,
      .i_debug_addr (i_debug_addr),
      .o_debug_data (o_debug_data)
`endif
   );

   // MEM/WB register; load sizing is captured here and applied to the RAM's registered word
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_wb_write      <= 1'b0;
         r_wb_mem_to_reg <= 1'b0;
         r_alu_result    <= '0;
         r_write_reg     <= '0;
         r_load          <= 1'b0;
         r_load_size     <= SZ_WORD;
         r_load_unsigned <= 1'b0;
      end else if (!i_halt) begin
         r_wb_write      <= i_WB_write;
         r_wb_mem_to_reg <= i_WB_mem_to_reg;
         r_alu_result    <= i_ALU_result;
         r_write_reg     <= i_write_reg;
         r_load          <= i_MEM_read;
         r_load_size     <= i_MEM_byte_half_word;
         r_load_unsigned <= i_MEM_unsigned;
      end
   end

   assign o_WB_write      = r_wb_write;
   assign o_WB_mem_to_reg = r_wb_mem_to_reg;
   assign o_ALU_result    = r_alu_result;
   assign o_write_reg     = r_write_reg;
   assign o_read_data     = r_load ? size_data(w_mem_q, r_load_size, r_load_unsigned) : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/store/halt/reset scenarios followed
// by randomized traffic compared against an array-based memory model.
module tb_mem_stage;

   localparam int MEM_DEPTH = 256;
   localparam logic [1:0] SZB = 2'b00;
   localparam logic [1:0] SZH = 2'b01;
   localparam logic [1:0] SZW = 2'b11;

   logic        i_clk;
   logic        i_reset;
   logic        i_halt;
   logic [4:0]  i_write_reg;
   logic [31:0] i_data_to_write_in_MEM;
   logic [31:0] i_ALU_result;
   logic        i_WB_write;
   logic        i_WB_mem_to_reg;
   logic        i_MEM_read;
   logic        i_MEM_write;
   logic        i_MEM_unsigned;
   logic [1:0]  i_MEM_byte_half_word;
   logic        o_WB_write;
   logic        o_WB_mem_to_reg;
   logic [31:0] o_ALU_result;
   logic [31:0] o_read_data;
   logic [4:0]  o_write_reg;
`ifdef MEM_DEBUG_PORT_EN
   logic [7:0]  dbgAddr;
   logic [31:0] dbgData;
`endif

   logic [31:0] memModel [MEM_DEPTH];
   logic [31:0] expWb, expM2r, expAlu, expRead, expReg;
   int vecCount = 0;
   int errCount = 0;

   mem_stage dut (
      .i_clk                  (i_clk),
      .i_reset                (i_reset),
      .i_halt                 (i_halt),
      .i_write_reg            (i_write_reg),
      .i_data_to_write_in_MEM (i_data_to_write_in_MEM),
      .i_ALU_result           (i_ALU_result),
      .i_WB_write             (i_WB_write),
      .i_WB_mem_to_reg        (i_WB_mem_to_reg),
      .i_MEM_read             (i_MEM_read),
      .i_MEM_write            (i_MEM_write),
      .i_MEM_unsigned         (i_MEM_unsigned),
      .i_MEM_byte_half_word   (i_MEM_byte_half_word),
      .o_WB_write             (o_WB_write),
      .o_WB_mem_to_reg        (o_WB_mem_to_reg),
      .o_ALU_result           (o_ALU_result),
      .o_read_data            (o_read_data),
      .o_write_reg            (o_write_reg)
`ifdef MEM_DEBUG_PORT_EN
      ,
      .i_debug_addr           (dbgAddr),
      .o_debug_data           (dbgData)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Reference sizing: keep the low n bits, then reinterpret as signed if requested
   function automatic logic [31:0] sizeExt(input logic [31:0] d, input logic [1:0] sz, input logic uns);
      logic [31:0] v;
      int n;
      n = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
      if (n == 32) return d;
      v = d % (32'd1 << n);
      if (!uns && v >= (32'd1 << (n - 1))) v = v - (32'd1 << n);
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      if (obs !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, ".wb"},   {31'b0, o_WB_write},      expWb);
      checkOutput({tag, ".m2r"},  {31'b0, o_WB_mem_to_reg}, expM2r);
      checkOutput({tag, ".alu"},  o_ALU_result,             expAlu);
      checkOutput({tag, ".rd"},   o_read_data,              expRead);
      checkOutput({tag, ".reg"},  {27'b0, o_write_reg},     expReg);
   endtask

   // Called at a falling edge: drives inputs, advances the model across the rising edge, checks
   task automatic applyStimulus(input string tag, input logic halt, input logic we, input logic re,
                                input logic uns, input logic [1:0] sz, input logic [31:0] alu,
                                input logic [31:0] data, input logic wbw, input logic m2r,
                                input logic [4:0] wreg);
      int idx;
      logic [31:0] old;
      i_halt = halt; i_MEM_write = we; i_MEM_read = re; i_MEM_unsigned = uns;
      i_MEM_byte_half_word = sz; i_ALU_result = alu; i_data_to_write_in_MEM = data;
      i_WB_write = wbw; i_WB_mem_to_reg = m2r; i_write_reg = wreg;
      @(posedge i_clk);
      if (!halt) begin
         idx = int'((alu >> 2) % MEM_DEPTH);
         old = memModel[idx];
         expRead = re ? sizeExt(old, sz, uns) : 32'h0;
         if (we) memModel[idx] = sizeExt(data, sz, uns);
         expWb = {31'b0, wbw}; expM2r = {31'b0, m2r}; expAlu = alu; expReg = {27'b0, wreg};
      end
      @(negedge i_clk);
      checkState(tag);
   endtask

   task automatic storeOp(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz, input logic uns);
      applyStimulus("st", 1'b0, 1'b1, 1'b0, uns, sz, addr, data, 1'b0, 1'b0, 5'd0);
   endtask

   task automatic loadOp(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
      applyStimulus("ld", 1'b0, 1'b0, 1'b1, uns, sz, addr, 32'h0, 1'b1, 1'b1, addr[6:2]);
   endtask

   // Asserts reset between edges with a store pending, holds it across one rising edge
   task automatic asyncReset(input logic [31:0] addr, input logic [31:0] data);
      i_halt = 1'b0; i_MEM_write = 1'b1; i_MEM_read = 1'b0; i_MEM_byte_half_word = SZW;
      i_ALU_result = addr; i_data_to_write_in_MEM = data;
      #2 i_reset = 1'b0;
      #1;
      checkOutput("arst.wb",  {31'b0, o_WB_write},      32'h0);
      checkOutput("arst.m2r", {31'b0, o_WB_mem_to_reg}, 32'h0);
      checkOutput("arst.alu", o_ALU_result,             32'h0);
      checkOutput("arst.reg", {27'b0, o_write_reg},     32'h0);
      checkOutput("arst.rd",  o_read_data,              32'h0);
      @(posedge i_clk);
      @(negedge i_clk);
      expWb = 0; expM2r = 0; expAlu = 0; expRead = 0; expReg = 0;
      checkState("arst_hold");
      i_reset = 1'b1;
   endtask

   initial begin
      logic [31:0] prev;
      i_reset = 1'b0; i_halt = 1'b0; i_write_reg = '0; i_data_to_write_in_MEM = '0;
      i_ALU_result = '0; i_WB_write = 1'b0; i_WB_mem_to_reg = 1'b0; i_MEM_read = 1'b0;
      i_MEM_write = 1'b0; i_MEM_unsigned = 1'b0; i_MEM_byte_half_word = SZW;
`ifdef MEM_DEBUG_PORT_EN
      dbgAddr = '0;
`endif
      expWb = 0; expM2r = 0; expAlu = 0; expRead = 0; expReg = 0;
      repeat (2) @(negedge i_clk);
      checkState("reset");
      i_reset = 1'b1;

      for (int i = 0; i < MEM_DEPTH; i++) storeOp(i * 4, $urandom, SZW, 1'b0);

      for (int k = 0; k < 20; k++) storeOp(4 * k, k, SZW, 1'b0);
      for (int k = 0; k < 20; k++) begin
         loadOp(4 * k, SZW, 1'b0);
         checkOutput("word_ld", o_read_data, k);
      end

      for (int k = 0; k < 20; k++) storeOp(4 * k, 32'hFFFFFFFF - k, SZH, 1'b1);
      for (int k = 0; k < 20; k++) begin
         loadOp(4 * k, SZH, 1'b1);
         checkOutput("half_u", o_read_data, 32'h0000FFFF & (32'hFFFFFFFF - k));
      end

      for (int k = 0; k < 20; k++) storeOp(4 * k, 32'hFFFFFFFF - k, SZB, 1'b1);
      for (int k = 0; k < 20; k++) begin
         loadOp(4 * k, SZB, 1'b1);
         checkOutput("byte_u", o_read_data, 32'h000000FF & (32'hFFFFFFFF - k));
      end

      for (int k = 0; k < 20; k++) storeOp(4 * k, 32'hFF - k, SZW, 1'b0);
      for (int k = 0; k < 20; k++) begin
         loadOp(4 * k, SZB, 1'b0);
         checkOutput("byte_s_ld", o_read_data, 32'hFFFFFFFF - k);
      end

      for (int k = 0; k < 20; k++) storeOp(4 * k, 32'hFF - k, SZB, 1'b0);
      for (int k = 0; k < 20; k++) begin
         loadOp(4 * k, SZW, 1'b1);
         checkOutput("byte_s_st", o_read_data, 32'hFFFFFFFF - k);
      end

      storeOp(40, 32'h0000A5A5, SZW, 1'b0);
      applyStimulus("rbw", 1'b0, 1'b1, 1'b1, 1'b0, SZW, 40, 32'h00005A5A, 1'b0, 1'b0, 5'd3);
      checkOutput("rbw_old", o_read_data, 32'h0000A5A5);
      loadOp(40, SZW, 1'b0);
      checkOutput("rbw_new", o_read_data, 32'h00005A5A);

      storeOp(32'h00000408, 32'h00001234, SZW, 1'b0);
      loadOp(11, 2'b10, 1'b0);
      checkOutput("wrap", o_read_data, 32'h00001234);

      storeOp(0, 32'h00000077, SZW, 1'b0);
      applyStimulus("halt0", 1'b0, 1'b0, 1'b0, 1'b0, SZW, 12, 32'h0, 1'b1, 1'b1, 5'd5);
      applyStimulus("halt1", 1'b1, 1'b1, 1'b0, 1'b0, SZW, 1, 32'hDEAD, 1'b0, 1'b0, 5'd2);
      applyStimulus("halt2", 1'b1, 1'b1, 1'b0, 1'b0, SZW, 1, 32'hDEAD, 1'b0, 1'b0, 5'd2);
      checkOutput("halt.wb",  {31'b0, o_WB_write},      32'd1);
      checkOutput("halt.m2r", {31'b0, o_WB_mem_to_reg}, 32'd1);
      checkOutput("halt.alu", o_ALU_result,             32'd12);
      checkOutput("halt.reg", {27'b0, o_write_reg},     32'd5);
      loadOp(0, SZW, 1'b0);
      checkOutput("halt_nowr", o_read_data, 32'h00000077);

      loadOp(44, SZW, 1'b0);
      prev = o_read_data;
      asyncReset(44, ~prev);
      loadOp(44, SZW, 1'b0);
      checkOutput("rst_abort", o_read_data, memModel[11]);

      for (int n = 0; n < 400; n++) begin
         logic [31:0] addr;
         addr = ($urandom_range(0, 1) == 1) ? $urandom : (($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
         applyStimulus("rnd", ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                       2'($urandom_range(0, 3)), addr, $urandom, 1'($urandom), 1'($urandom),
                       5'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
